param_fix_division: RTL and testbench

PARAM_FIX_DIVISION -- requirements
Module: param_fix_division

---
 rtl/param_fix_division.sv | 128 ++++++++++++
 tb/tb_param_fix_division.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/param_fix_division.sv
// Sequential restoring divider for fixed-point magnitudes: one quotient bit per cycle,
// WIDTH+FRAC quotient bits, plus binary-point and sign bookkeeping.
module param_fix_division #(
  parameter int WIDTH = 64,
  parameter int FRAC  = 64,
  parameter int DW    = 7
) (
  input  logic                    systclk,
  input  logic                    sysrst,
  input  logic                    init,
  input  logic [WIDTH-1:0]        dividend,
  input  logic [WIDTH-1:0]        divisor,
  input  logic [DW-1:0]           dotplace_n,
  input  logic [DW-1:0]           dotplace_d,
  input  logic                    sign_n,
  input  logic                    sign_d,
  output logic [WIDTH+FRAC-1:0]   result,
  output logic [WIDTH-1:0]        remainder,
  output logic [DW+1:0]           dotplaceresult,
  output logic                    signresult,
  output logic                    busy,
  output logic                    calcover,
  output logic                    divzero
);

  localparam int QW  = WIDTH + FRAC;
  localparam int CW  = $clog2(QW + 1);
  localparam int DPW = DW + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   rem_r;
  logic [QW-1:0]    quo_r;
  logic [DPW-1:0]   dp_r;
  logic             sgn_r;
  logic             dz_r;

  logic [WIDTH:0]   part_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;

  // One restoring step: bring down the next dividend bit and trial-subtract the divisor
  always_comb begin
    part_s = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
    diff_s = part_s - {1'b0, dsr_r};
    if (part_s >= {1'b0, dsr_r}) begin
      ge_s = 1'b1;
    end else begin
      ge_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge systclk) begin
    if (sysrst) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      dvd_r          <= '0;
      dsr_r          <= '0;
      rem_r          <= '0;
      quo_r          <= '0;
      dp_r           <= '0;
      sgn_r          <= 1'b0;
      dz_r           <= 1'b0;
      result         <= '0;
      remainder      <= '0;
      dotplaceresult <= '0;
      signresult     <= 1'b0;
      busy           <= 1'b0;
      calcover       <= 1'b0;
      divzero        <= 1'b0;
    end else begin
      calcover <= 1'b0;
      case (state_r)
        IDLE: begin
          if (init) begin
            dvd_r   <= dividend;
            dsr_r   <= divisor;
            rem_r   <= '0;
            quo_r   <= '0;
            cnt_r   <= '0;
            dp_r    <= DPW'(FRAC) + {2'b00, dotplace_n} - {2'b00, dotplace_d};
            sgn_r   <= sign_n ^ sign_d;
            dz_r    <= (divisor == '0);
            busy    <= 1'b1;
            state_r <= (divisor == '0) ? DONE : CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          // Zeros feed in once the dividend bits are exhausted, yielding the FRAC bits
          dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
          rem_r <= ge_s ? diff_s : part_s;
          quo_r <= {quo_r[QW-2:0], ge_s};
          if (cnt_r == CW'(QW - 1)) begin
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
            state_r <= CALC;
          end
        end
        DONE: begin
          result         <= dz_r ? {QW{1'b1}} : quo_r;
          remainder      <= dz_r ? '0 : rem_r[WIDTH-1:0];
          dotplaceresult <= dp_r;
          // A zero quotient is reported as positive; divide-by-zero keeps the raw sign
          signresult     <= sgn_r & (dz_r | (quo_r != '0));
          divzero        <= dz_r;
          calcover       <= 1'b1;
          busy           <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_fix_division.sv
// Scoreboard bench for param_fix_division at WIDTH=8, FRAC=8, DW=7: expected results
// are queued when an operation is accepted and compared on calcover.
module tb_param_fix_division;

  localparam int W  = 8;
  localparam int F  = 8;
  localparam int D  = 7;
  localparam int QW = W + F;

  logic            systclk = 1'b0;
  logic            sysrst;
  logic            init;
  logic [W-1:0]    dividend, divisor;
  logic [D-1:0]    dotplace_n, dotplace_d;
  logic            sign_n, sign_d;
  logic [QW-1:0]   result;
  logic [W-1:0]    remainder;
  logic [D+1:0]    dotplaceresult;
  logic            signresult, busy, calcover, divzero;

  typedef struct {
    logic [QW-1:0] res;
    logic [W-1:0]  rem;
    logic [D+1:0]  dp;
    logic          sgn;
    logic          dz;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            cyc    = 0;
  logic [QW-1:0] last_res = '0;

  param_fix_division #(.WIDTH(W), .FRAC(F), .DW(D)) dut (
    .systclk(systclk), .sysrst(sysrst), .init(init),
    .dividend(dividend), .divisor(divisor),
    .dotplace_n(dotplace_n), .dotplace_d(dotplace_d),
    .sign_n(sign_n), .sign_d(sign_d),
    .result(result), .remainder(remainder), .dotplaceresult(dotplaceresult),
    .signresult(signresult), .busy(busy), .calcover(calcover), .divzero(divzero)
  );

  always #5 systclk = ~systclk;

  always @(posedge systclk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                                 input logic [D-1:0] dpn, input logic [D-1:0] dpd,
                                 input logic sn, input logic sd, input int acc);
    exp_t e;
    logic [31:0] num;
    num  = 32'(dvd) << F;
    e.dp = 9'(F + int'(dpn) - int'(dpd));
    if (dsr == 8'd0) begin
      e.res = 16'hFFFF; e.rem = 8'd0; e.dz = 1'b1; e.sgn = sn ^ sd; e.due = acc + 1;
    end else begin
      e.res = 16'(num / 32'(dsr));
      e.rem = 8'(num % 32'(dsr));
      e.dz  = 1'b0;
      e.sgn = (sn ^ sd) && (e.res != 16'd0);
      e.due = acc + QW + 1;
    end
    return e;
  endfunction

  // Completion monitor: every calcover must match the oldest queued expectation
  always @(negedge systclk) begin
    if (!sysrst && calcover) begin
      if (sb.size() == 0) begin
        check("spurious_calcover", calcover, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("remainder", remainder, e.rem);
        check("dotplace", dotplaceresult, e.dp);
        check("sign", signresult, e.sgn);
        check("divzero", divzero, e.dz);
        check("latency", cyc, e.due);
        last_res = e.res;
      end
    end
  end

  task automatic drive(input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                       input logic [D-1:0] dpn, input logic [D-1:0] dpd,
                       input logic sn, input logic sd);
    dividend = dvd; divisor = dsr; dotplace_n = dpn; dotplace_d = dpd;
    sign_n = sn; sign_d = sd; init = 1'b1;
    @(posedge systclk); #1;
    init = 1'b0;
    sb.push_back(model(dvd, dsr, dpn, dpd, sn, sd, cyc));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge systclk);
    if (sb.size() != 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(posedge systclk); #1;
  endtask

  initial begin
    sysrst = 1'b1; init = 1'b0; dividend = '0; divisor = '0;
    dotplace_n = '0; dotplace_d = '0; sign_n = 1'b0; sign_d = 1'b0;
    repeat (3) @(posedge systclk);
    @(negedge systclk);
    check("rst_busy", busy, 1'b0);
    check("rst_calcover", calcover, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_dotplace", dotplaceresult, 9'h000);
    @(posedge systclk); #1;
    sysrst = 1'b0;

    drive(8'd6, 8'd3, 7'd0, 7'd0, 1'b0, 1'b0);   wait_idle();
    drive(8'd1, 8'd3, 7'd0, 7'd0, 1'b1, 1'b0);   wait_idle();
    drive(8'd0, 8'd5, 7'd0, 7'd0, 1'b1, 1'b0);   wait_idle();
    drive(8'd255, 8'd1, 7'd2, 7'd5, 1'b0, 1'b1); wait_idle();
    drive(8'd17, 8'd255, 7'd0, 7'd100, 1'b1, 1'b1); wait_idle();
    drive(8'd9, 8'd0, 7'd3, 7'd1, 1'b1, 1'b0);   wait_idle();

    repeat (5) @(posedge systclk);
    @(negedge systclk);
    check("hold_result", result, last_res);
    check("hold_divzero", divzero, 1'b1);
    @(posedge systclk); #1;

    for (int k = 0; k < 6; k++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle();
    end

    // init pulsed mid-operation with new operands must not disturb the first division
    drive(8'd100, 8'd7, 7'd4, 7'd1, 1'b0, 1'b1);
    repeat (3) @(posedge systclk); #1;
    dividend = 8'd1; divisor = 8'd1; sign_d = 1'b0; init = 1'b1;
    @(posedge systclk); #1;
    init = 1'b0;
    check("mid_busy", busy, 1'b1);
    wait_idle();

    // init held high: second division accepted on the edge closing the calcover cycle
    begin
      int a;
      dividend = 8'd200; divisor = 8'd9; dotplace_n = 7'd1; dotplace_d = 7'd2;
      sign_n = 1'b1; sign_d = 1'b0; init = 1'b1;
      @(posedge systclk); #1;
      a = cyc;
      sb.push_back(model(8'd200, 8'd9, 7'd1, 7'd2, 1'b1, 1'b0, a));
      sb.push_back(model(8'd200, 8'd9, 7'd1, 7'd2, 1'b1, 1'b0, a + QW + 2));
      repeat (QW + 2) @(posedge systclk); #1;
      init = 1'b0;
      check("b2b_busy", busy, 1'b1);
      wait_idle();
    end

    // Reset during CALC with init high aborts cleanly
    drive(8'd200, 8'd7, 7'd5, 7'd0, 1'b1, 1'b0);
    repeat (4) @(posedge systclk); #1;
    sysrst = 1'b1; init = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(posedge systclk); #1;
    sysrst = 1'b0; init = 1'b0;
    sb.delete();
    @(negedge systclk);
    check("abort_busy", busy, 1'b0);
    check("abort_calcover", calcover, 1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_remainder", remainder, 8'h00);
    check("abort_sign", signresult, 1'b0);
    check("abort_divzero", divzero, 1'b0);
    check("abort_dotplace", dotplaceresult, 9'h000);
    repeat (QW + 4) @(negedge systclk);
    @(posedge systclk); #1;
    drive(8'd6, 8'd3, 7'd0, 7'd0, 1'b0, 1'b0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
